// File: rtl/mips32_prog_loader.sv
// Program loader for a MIPS32 core: packs a big-endian byte stream into 32-bit
// instruction words, writes them to instruction memory, then releases the CPU.
module mips32_prog_loader #(
  parameter int ADDR_W    = 10,
  parameter int MAX_WORDS = 1024
) (
  input  logic              clk1,
  input  logic              rst,
  input  logic              load_start,
  input  logic              in_valid,
  input  logic [7:0]        in_byte,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              cpu_hold,
  output logic              cpu_start,
  output logic [ADDR_W:0]   word_count,
  output logic              err_overflow
);
  localparam logic [31:0]       HLT_WORD  = 32'hfc000000;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(MAX_WORDS - 1);
  localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);
  localparam logic [ADDR_W:0]   CNT_ONE   = (ADDR_W + 1)'(1);

  typedef enum logic [1:0] {IDLE, COLLECT, WRITE, DONE} state_t;

  state_t            state_q, state_d;
  logic [1:0]        byte_cnt_q, byte_cnt_d;
  logic [31:0]       word_q, word_d;
  logic              in_ready_q, in_ready_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [31:0]       mem_wdata_q, mem_wdata_d;
  logic              cpu_hold_q, cpu_hold_d;
  logic              cpu_start_q, cpu_start_d;
  logic [ADDR_W:0]   word_count_q, word_count_d;
  logic              err_overflow_q, err_overflow_d;

  always_comb begin
    state_d        = state_q;
    byte_cnt_d     = byte_cnt_q;
    word_d         = word_q;
    in_ready_d     = in_ready_q;
    mem_we_d       = 1'b0;
    mem_addr_d     = mem_addr_q;
    mem_wdata_d    = mem_wdata_q;
    cpu_hold_d     = cpu_hold_q;
    cpu_start_d    = 1'b0;
    word_count_d   = word_count_q;
    err_overflow_d = err_overflow_q;

    unique case (state_q)
      IDLE: begin
        if (load_start) begin
          state_d        = COLLECT;
          in_ready_d     = 1'b1;
          cpu_hold_d     = 1'b1;
          mem_addr_d     = '0;
          byte_cnt_d     = '0;
          word_count_d   = '0;
          err_overflow_d = 1'b0;
        end
      end
      COLLECT: begin
        if (in_valid && in_ready_q) begin
          word_d     = {word_q[23:0], in_byte};
          byte_cnt_d = byte_cnt_q + 2'd1;
          // Outputs are registered, so the write strobe is launched together
          // with the 4th byte to land in the very next cycle.
          if (byte_cnt_q == 2'd3) begin
            state_d      = WRITE;
            in_ready_d   = 1'b0;
            mem_we_d     = 1'b1;
            mem_wdata_d  = word_d;
            word_count_d = word_count_q + CNT_ONE;
          end
        end
      end
      WRITE: begin
        // HLT wins over the overflow check on the final slot.
        if (mem_wdata_q == HLT_WORD) begin
          state_d     = DONE;
          cpu_start_d = 1'b1;
          cpu_hold_d  = 1'b0;
        end else if (mem_addr_q == LAST_ADDR) begin
          state_d        = DONE;
          cpu_start_d    = 1'b1;
          cpu_hold_d     = 1'b0;
          err_overflow_d = 1'b1;
        end else begin
          state_d    = COLLECT;
          mem_addr_d = mem_addr_q + ADDR_ONE;
          in_ready_d = 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk1) begin
    if (rst) begin
      state_q        <= IDLE;
      byte_cnt_q     <= '0;
      word_q         <= '0;
      in_ready_q     <= 1'b0;
      mem_we_q       <= 1'b0;
      mem_addr_q     <= '0;
      mem_wdata_q    <= '0;
      cpu_hold_q     <= 1'b0;
      cpu_start_q    <= 1'b0;
      word_count_q   <= '0;
      err_overflow_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      byte_cnt_q     <= byte_cnt_d;
      word_q         <= word_d;
      in_ready_q     <= in_ready_d;
      mem_we_q       <= mem_we_d;
      mem_addr_q     <= mem_addr_d;
      mem_wdata_q    <= mem_wdata_d;
      cpu_hold_q     <= cpu_hold_d;
      cpu_start_q    <= cpu_start_d;
      word_count_q   <= word_count_d;
      err_overflow_q <= err_overflow_d;
    end
  end

  assign in_ready     = in_ready_q;
  assign mem_we       = mem_we_q;
  assign mem_addr     = mem_addr_q;
  assign mem_wdata    = mem_wdata_q;
  assign cpu_hold     = cpu_hold_q;
  assign cpu_start    = cpu_start_q;
  assign word_count   = word_count_q;
  assign err_overflow = err_overflow_q;

endmodule

// File: doc/mips32_prog_loader.md
MIPS32_PROG_LOADER -- requirements
Module: mips32_prog_loader

Interface
REQ-001 SHALL have parameter ADDR_W, default 10, meaning width of the instruction-memory word address.
REQ-002 SHALL have parameter MAX_WORDS, default 1024, meaning the highest loadable word count (at most 2^ADDR_W).
REQ-003 SHALL have port clk1  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset; synchronous and active-high.
REQ-005 SHALL have port load_start  input  1  request to begin a program load.
REQ-006 SHALL have port in_valid  input  1  in_byte carries a valid program byte.
REQ-007 SHALL have port in_byte  input  8  program byte stream, big-endian within each 32-bit word.
REQ-008 SHALL have port in_ready  output  1  loader accepts in_byte this cycle.
REQ-009 SHALL have port mem_we  output  1  instruction-memory write strobe.
REQ-010 SHALL have port mem_addr  output  ADDR_W  instruction-memory word address.
REQ-011 SHALL have port mem_wdata  output  32  instruction word to write.
REQ-012 SHALL have port cpu_hold  output  1  holds the CPU halted (drives HALTED) while loading.
REQ-013 SHALL have port cpu_start  output  1  one-cycle pulse: CPU may clear HALTED and TAKEN_BRANCH and start at PC=0.
REQ-014 SHALL have port word_count  output  ADDR_W+1  number of words written in the current or last load.
REQ-015 SHALL have port err_overflow  output  1  last load ended at MAX_WORDS without HLT.

Function
REQ-016 SHALL implement FSM states IDLE, COLLECT, WRITE, DONE; all outputs registered.
REQ-017 IDLE: in_ready=0, mem_we=0. load_start=1 -> COLLECT; this clears mem_addr, the byte counter, word_count, and err_overflow, and sets cpu_hold=1.
REQ-018 COLLECT: in_ready=1. A byte is accepted only when in_valid&in_ready; the word shifts as {word[23:0], in_byte}. in_valid=0 stalls indefinitely with no state change.
REQ-019 COLLECT: 4th accepted byte -> WRITE in the next cycle; the byte counter wraps 3->0.
REQ-020 WRITE: exactly one cycle; mem_we=1, mem_wdata=assembled word, mem_addr=current address, in_ready=0; word_count increments by 1.
REQ-021 WRITE exit: word == 32'hfc000000 (HLT) -> DONE; else mem_addr == MAX_WORDS-1 -> DONE with err_overflow=1; else mem_addr+1 -> COLLECT.
REQ-022 HLT check SHALL take priority over overflow when both occur on the same word; err_overflow stays 0.
REQ-023 DONE: exactly one cycle; cpu_start=1, cpu_hold=0 from this cycle on; next state IDLE.
REQ-024 Latency: mem_we SHALL assert in the cycle immediately after the 4th byte is accepted; peak throughput 1 word per 5 cycles.
REQ-025 load_start SHALL be ignored in every state except IDLE.
REQ-026 mem_addr, mem_wdata, and word_count SHALL hold their last values in IDLE; err_overflow persists until the next load_start.

Reset
REQ-027 rst=1 SHALL force state IDLE with in_ready, mem_we, cpu_hold, cpu_start, and err_overflow at 0, and mem_addr, mem_wdata, word_count, and the byte counter at 0.
REQ-028 rst asserted mid-load SHALL abort the load with no further mem_we and no cpu_start pulse; a partial word is discarded.
REQ-029 rst SHALL take priority over load_start and in_valid in the same cycle.

Verification
REQ-030 Bytes 28 01 00 0a, 28 02 00 14, fc 00 00 00 sent back-to-back -> writes 2801000a@0, 28020014@1, fc000000@2; word_count=3; one cpu_start pulse; err_overflow=0.
REQ-031 Bytes 00 22 20 00 with in_valid low for 3 cycles between bytes -> a single mem_we with 00222000@0, 1 cycle after the last byte; no write before then.
REQ-032 MAX_WORDS=4 and 4 non-HLT words -> writes at 0..3, then DONE with err_overflow=1, cpu_start pulse, word_count=4.
REQ-033 rst after 2 words plus 2 bytes of a 3rd -> no further mem_we, no cpu_start; all outputs 0 in the next cycle.
REQ-034 load_start pulsed during COLLECT -> no effect (mem_addr is not cleared); a second load after DONE restarts at address 0 and clears err_overflow.
